bp_skid_pipe: RTL and testbench

BP_SKID_PIPE -- requirements
Module: bp_skid_pipe

---
 rtl/bp_pkg.sv | 15 +
 rtl/bp_skid_stage.sv | 81 ++++++++
 rtl/bp_skid_pipe.sv | 78 +++++++
 tb/tb_bp_skid_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the bp_skid_pipe skid-buffer chain.
// Stage state encoding doubles as the stage entry count.
package bp_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_st_e;

  function automatic int occ_w(input int pipes);
    return (pipes == 0) ? 1 : $clog2(2 * pipes + 1);
  endfunction

endpackage

// File: rtl/bp_skid_stage.sv
// One fully registered skid stage: main entry plus skid entry.
// Upstream ready and downstream valid decode only from the state flop.
module bp_skid_stage
  import bp_pkg::*;
#(
  parameter int DATAW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DATAW-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [DATAW-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [1:0]       cnt_o
);

  stage_st_e        state_q, state_d;
  logic [DATAW-1:0] main_q, main_d;
  logic [DATAW-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = data_i;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = data_i;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = data_i;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    ready_o = (state_q != FULL);
    valid_o = (state_q != EMPTY);
    data_o  = main_q;
    unique case (state_q)
      ONE:     cnt_o = 2'd1;
      FULL:    cnt_o = 2'd2;
      default: cnt_o = 2'd0;
    endcase
  end

endmodule

// File: rtl/bp_skid_pipe.sv
// Chain of PIPES skid stages; PIPES=0 is a wire-through.
// Define BP_SKID_PIPE_ASSERT_EN to compile handshake assertions.
module bp_skid_pipe
  import bp_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int PIPES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATAW-1:0]          data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [DATAW-1:0]          data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [occ_w(PIPES)-1:0]   occ_o
);

  localparam int OCCW = occ_w(PIPES);

  if (PIPES == 0) begin : g_pass
    assign data_o  = data_i;
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign occ_o   = '0;
  end else begin : g_pipe
    logic [DATAW-1:0] d   [PIPES+1];
    logic             v   [PIPES+1];
    logic             r   [PIPES+1];
    logic [1:0]       cnt [PIPES];
    logic [OCCW-1:0]  occ_sum;

    assign d[0]     = data_i;
    assign v[0]     = valid_i;
    assign ready_o  = r[0];
    assign data_o   = d[PIPES];
    assign valid_o  = v[PIPES];
    assign r[PIPES] = ready_i;

    for (genvar i = 0; i < PIPES; i++) begin : g_stage
      bp_skid_stage #(
        .DATAW(DATAW)
      ) u_stage (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (d[i]),
        .valid_i(v[i]),
        .ready_o(r[i]),
        .data_o (d[i+1]),
        .valid_o(v[i+1]),
        .ready_i(r[i+1]),
        .cnt_o  (cnt[i])
      );
    end

    always_comb begin
      occ_sum = '0;
      for (int i = 0; i < PIPES; i++) begin
        occ_sum = occ_sum + OCCW'(cnt[i]);
      end
    end

    assign occ_o = occ_sum;
  end

`ifdef BP_SKID_PIPE_ASSERT_EN
  a_vld_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_i && !ready_o |=> valid_i);
  a_dat_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_i && !ready_o |=> $stable(data_i));
  a_occ_max: assert property (@(posedge clk_i)
    occ_o <= OCCW'(2 * PIPES));
  a_rst_vld: assert property (@(posedge clk_i)
    rst_i && (PIPES != 0) |-> !valid_o);
`endif

endmodule

// File: tb/tb_bp_skid_pipe.sv
// Scoreboard bench for bp_skid_pipe at PIPES=2, PIPES=3 and PIPES=0.
// Index 0 drives the PIPES=2 instance, index 1 the PIPES=3 instance.
module tb_bp_skid_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din  [2];
  logic       vin  [2];
  logic       rin  [2];
  logic       rdy  [2];
  logic       vout [2];
  logic [7:0] dout [2];
  logic [2:0] occ  [2];

  logic [7:0] c_d, c_dout;
  logic       c_v, c_r, c_rdy, c_vout;
  logic [0:0] c_occ;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         n_out = 0;
  logic       last_in = 1'b0;
  logic       last_out = 1'b0;
  logic [7:0] last_od;

  always #5 clk = ~clk;

  bp_skid_pipe #(.DATAW(8), .PIPES(2)) u_p2 (
    .clk_i(clk), .rst_i(rst),
    .data_i(din[0]), .valid_i(vin[0]), .ready_o(rdy[0]),
    .data_o(dout[0]), .valid_o(vout[0]), .ready_i(rin[0]),
    .occ_o(occ[0])
  );

  bp_skid_pipe #(.DATAW(8), .PIPES(3)) u_p3 (
    .clk_i(clk), .rst_i(rst),
    .data_i(din[1]), .valid_i(vin[1]), .ready_o(rdy[1]),
    .data_o(dout[1]), .valid_o(vout[1]), .ready_i(rin[1]),
    .occ_o(occ[1])
  );

  bp_skid_pipe #(.DATAW(8), .PIPES(0)) u_p0 (
    .clk_i(clk), .rst_i(rst),
    .data_i(c_d), .valid_i(c_v), .ready_o(c_rdy),
    .data_o(c_dout), .valid_o(c_vout), .ready_i(c_r),
    .occ_o(c_occ)
  );

  // One clock of instance k: record handshakes, update the scoreboard.
  task automatic step(input int k);
    logic       pv, pr, pvin, prdy;
    logic [7:0] pd, pdin, exp_d;
    int         sz;
    @(negedge clk);
    pv = vout[k]; pr = rin[k]; pd = dout[k];
    pvin = vin[k]; prdy = rdy[k]; pdin = din[k];
    @(posedge clk);
    #1;
    cyc++;
    last_in  = pvin && prdy;
    last_out = pv && pr;
    last_od  = pd;
    if (last_in) begin
      if (k == 0) sb0.push_back(pdin);
      else        sb1.push_back(pdin);
    end
    if (last_out) begin
      n_out++;
      total++;
      sz = (k == 0) ? sb0.size() : sb1.size();
      if (sz == 0) begin
        bad++;
        $display("FAIL extra_out[%0d]: got %h, required no output", k, pd);
      end else begin
        exp_d = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        if (pd !== exp_d) begin
          bad++;
          $display("FAIL order[%0d]: got %h, required %h", k, pd, exp_d);
        end
      end
    end else if (pv) begin
      total++;
      if (dout[k] !== pd) begin
        bad++;
        $display("FAIL hold[%0d]: got %h, required %h", k, dout[k], pd);
      end
    end
    sz = (k == 0) ? sb0.size() : sb1.size();
    total++;
    if (occ[k] !== 3'(sz)) begin
      bad++;
      $display("FAIL occ[%0d]: got %0d, required %0d", k, occ[k], sz);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      din[k] = 8'h00; vin[k] = 1'b0; rin[k] = 1'b0;
    end
    c_d = 8'h00; c_v = 1'b0; c_r = 1'b0;
    #1;
    total++;
    if (vout[0] !== 1'b0 || rdy[0] !== 1'b1 ||
        dout[0] !== 8'h00 || occ[0] !== 3'd0) begin
      bad++;
      $display("FAIL reset_init: got v=%b r=%b d=%h occ=%0d, required 0 1 00 0",
               vout[0], rdy[0], dout[0], occ[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[0] = 8'h30 + 8'(i); vin[0] = 1'b1;
      step(0);
    end
    vin[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (vout[0] !== 1'b0 || rdy[0] !== 1'b1 ||
        dout[0] !== 8'h00 || occ[0] !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid: got v=%b r=%b d=%h occ=%0d, required 0 1 00 0",
               vout[0], rdy[0], dout[0], occ[0]);
    end
    sb0.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    din[0] = 8'h55; vin[0] = 1'b1;
    step(0);
    total++;
    if (last_in !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_xfer: got %b, required 1", last_in);
    end
    vin[0] = 1'b0; rin[0] = 1'b1;
    for (int i = 0; i < 8 && sb0.size() > 0; i++) step(0);
  endtask

  task automatic test_stream();
    int first_c = -1;
    int prev_c = -1;
    int exp_c;
    rin[0] = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (i < 16) begin
        din[0] = 8'(i + 1); vin[0] = 1'b1;
      end else begin
        vin[0] = 1'b0;
      end
      step(0);
      if (i < 16) begin
        total++;
        if (last_in !== 1'b1) begin
          bad++;
          $display("FAIL stream_accept: got %b, required 1 at input %0d", last_in, i);
        end
        if (i == 0) first_c = cyc;
      end
      if (last_out) begin
        exp_c = (prev_c < 0) ? first_c + 2 : prev_c + 1;
        total++;
        if (cyc !== exp_c) begin
          bad++;
          $display("FAIL stream_timing: got cycle %0d, required %0d", cyc, exp_c);
        end
        prev_c = cyc;
      end
    end
    total++;
    if (sb0.size() !== 0) begin
      bad++;
      $display("FAIL stream_left: got %0d pending, required 0", sb0.size());
    end
  endtask

  task automatic test_fill();
    rin[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din[0] = 8'hA0 + 8'(i); vin[0] = 1'b1;
      step(0);
      total++;
      if (last_in !== 1'b1) begin
        bad++;
        $display("FAIL fill_accept: got %b, required 1 for %0d", last_in, i);
      end
    end
    total++;
    if (rdy[0] !== 1'b0 || occ[0] !== 3'd4) begin
      bad++;
      $display("FAIL fill_full: got r=%b occ=%0d, required r=0 occ=4", rdy[0], occ[0]);
    end
    din[0] = 8'hA4; vin[0] = 1'b1;
    step(0);
    total++;
    if (last_in !== 1'b0 || occ[0] !== 3'd4) begin
      bad++;
      $display("FAIL fill_reject: got in=%b occ=%0d, required in=0 occ=4",
               last_in, occ[0]);
    end
  endtask

  task automatic test_drain();
    int n = 0;
    int t1 = 0;
    rin[0] = 1'b1;
    for (int i = 0; i < 12 && (sb0.size() > 0 || vin[0]); i++) begin
      step(0);
      if (last_in) vin[0] = 1'b0;
      if (last_out) begin
        n++;
        if (n == 1) t1 = cyc;
        if (n <= 4) begin
          total++;
          if (cyc !== t1 + n - 1) begin
            bad++;
            $display("FAIL drain_timing: got cycle %0d, required %0d", cyc, t1 + n - 1);
          end
        end
        if (n == 2) begin
          total++;
          if (rdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL drain_resume: got ready %b, required 1", rdy[0]);
          end
        end
        if (n == 5) begin
          total++;
          if (last_od !== 8'hA4) begin
            bad++;
            $display("FAIL drain_last: got %h, required a4", last_od);
          end
        end
      end
    end
    total++;
    if (n !== 5) begin
      bad++;
      $display("FAIL drain_count: got %0d, required 5", n);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    n_out = 0;
    last_in = 1'b0;
    vin[1] = 1'b0;
    for (int c = 0; c < 20000 && n_out < 1000; c++) begin
      if (vin[1] && !last_in) begin
        vin[1] = 1'b1;
      end else if (sent < 1000 && $urandom_range(1) == 1) begin
        vin[1] = 1'b1;
        din[1] = 8'($urandom);
        sent++;
      end else begin
        vin[1] = 1'b0;
      end
      rin[1] = 1'($urandom_range(1));
      step(1);
    end
    vin[1] = 1'b0;
    total++;
    if (n_out !== 1000 || sb1.size() !== 0) begin
      bad++;
      $display("FAIL random_count: got %0d out %0d pending, required 1000 out 0 pending",
               n_out, sb1.size());
    end
  endtask

  task automatic test_passthru();
    for (int i = 0; i < 8; i++) begin
      c_d = 8'($urandom);
      c_v = 1'($urandom_range(1));
      c_r = 1'($urandom_range(1));
      #1;
      total++;
      if (c_rdy !== c_r || c_dout !== c_d || c_vout !== c_v || c_occ !== 1'b0) begin
        bad++;
        $display("FAIL passthru: got r=%b d=%h v=%b occ=%0d, required r=%b d=%h v=%b occ=0",
                 c_rdy, c_dout, c_vout, c_occ, c_r, c_d, c_v);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_drain();
    test_random();
    test_passthru();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
